// File: rtl/audio_mixer_n_pkg.sv
//==============================================================================
// Package : audio_pkg
// Brief   : Shared types, default sizes and saturation helper for the audio
//           mixing path and its channel generators.
// Rev     : 1.0 - initial release
//==============================================================================
`default_nettype none

package audio_pkg;

  // Default channel layout: four PSG voices plus two direct-sound FIFOs
  localparam int AUDIO_NUM_CH = 6;
  localparam int AUDIO_IN_W   = 16;
  localparam int AUDIO_OUT_W  = 24;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    SCALE   = 2'd2,
    PRESENT = 2'd3
  } mixer_state_t;

  // Clamp a wide signed value into the signed range of 'width' bits
  function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                  input int width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (value > max_v) return max_v;
    if (value < min_v) return min_v;
    return value;
  endfunction

endpackage

`default_nettype wire

// File: rtl/audio_mixer_n_if.sv
//==============================================================================
// Interface : audio_mixer_n_if
// Brief     : Codec-side link of the mixer: sample request plus the stereo
//             sample valid/ready handshake.
// Rev       : 1.0 - initial release
//==============================================================================
`default_nettype none

interface audio_mixer_n_if
  import audio_pkg::*;
#(
  parameter int OUT_W = AUDIO_OUT_W
);
  logic                    sample_req;
  logic signed [OUT_W-1:0] out_l;
  logic signed [OUT_W-1:0] out_r;
  logic                    out_valid;
  logic                    out_ready;

  // Mixer side
  modport master (
    input  sample_req,
    input  out_ready,
    output out_l,
    output out_r,
    output out_valid
  );

  // Codec side
  modport slave (
    output sample_req,
    output out_ready,
    input  out_l,
    input  out_r,
    input  out_valid
  );
endinterface

`default_nettype wire

// File: rtl/audio_mixer_n_scale.sv
//==============================================================================
// Module  : audio_mix_scale
// Brief   : Combinational master-volume stage for one side: multiply the
//           accumulator by (master+1), arithmetic shift right by 3, saturate.
// Options : AUDIO_MIX_CLIP_STATUS_EN adds the 'clipped' indication output
// Rev     : 1.0 - initial release
//==============================================================================
`default_nettype none

module audio_mix_scale
  import audio_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int OUT_W = 24
)(
  input  logic signed [ACC_W-1:0] acc,
  input  logic        [2:0]       master,
  output logic signed [OUT_W-1:0] sample
`ifdef AUDIO_MIX_CLIP_STATUS_EN
  ,
  output logic                    clipped
`endif
);

  // Gain of up to 8 adds at most 4 bits of headroom before the shift
  localparam int c_PROD_W = ACC_W + 4;

  logic signed [4:0]          w_gain;
  logic signed [c_PROD_W-1:0] w_acc_x;
  logic signed [c_PROD_W-1:0] w_gain_x;
  logic signed [c_PROD_W-1:0] w_prod;
  logic signed [c_PROD_W-1:0] w_shift;
  logic signed [63:0]         w_wide;

  assign w_gain   = $signed({2'b00, master}) + 5'sd1;
  assign w_acc_x  = c_PROD_W'(acc);
  assign w_gain_x = c_PROD_W'(w_gain);
  assign w_prod   = w_acc_x * w_gain_x;
  assign w_shift  = w_prod >>> 3;
  assign w_wide   = 64'(w_shift);
  assign sample   = OUT_W'(saturate(w_wide, OUT_W));

`ifdef AUDIO_MIX_CLIP_STATUS_EN
  // Saturation happened whenever the narrowed sample no longer equals the wide value
  assign clipped = (64'(sample) != w_wide);
`endif

endmodule

`default_nettype wire

// File: rtl/audio_mixer_n.sv
//==============================================================================
// Module  : audio_mixer_n
// Brief   : N-channel stereo mixer. Snapshots all channels on a codec sample
//           request, accumulates one channel per cycle with volume and L/R
//           enables, applies 3-bit master volume, saturates and presents the
//           stereo sample on a valid/ready handshake.
// Options : AUDIO_MIX_CLIP_STATUS_EN adds sticky clip_l/clip_r outputs
// Rev     : 1.0 - initial release
//==============================================================================
`default_nettype none

module audio_mixer_n
  import audio_pkg::*;
#(
  parameter int NUM_CH = AUDIO_NUM_CH,
  parameter int IN_W   = AUDIO_IN_W,
  parameter int VOL_W  = 4,
  parameter int OUT_W  = AUDIO_OUT_W
)(
  input  logic                    clk_100,
  input  logic                    reset_n,
  audio_mixer_n_if.master         codec,
  input  logic [NUM_CH*IN_W-1:0]  ch_data,
  input  logic [NUM_CH*VOL_W-1:0] ch_vol,
  input  logic [NUM_CH-1:0]       ch_en_l,
  input  logic [NUM_CH-1:0]       ch_en_r,
  input  logic [2:0]              master_l,
  input  logic [2:0]              master_r,
  output logic                    busy,
  output logic                    missed_req,
  input  logic                    clr_status
`ifdef AUDIO_MIX_CLIP_STATUS_EN
  ,
  output logic                    clip_l,
  output logic                    clip_r
`endif
);

  // Wide enough that summing NUM_CH full-scale products can never overflow
  localparam int c_ACC_W = IN_W + VOL_W + $clog2(NUM_CH) + 1;
  localparam int c_IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  mixer_state_t r_state;
  mixer_state_t w_state_next;
  logic         w_load;
  logic         w_accum;
  logic         w_scale;
  logic         w_done;

  logic signed [IN_W-1:0]    r_snap_data [NUM_CH];
  logic        [VOL_W-1:0]   r_snap_vol  [NUM_CH];
  logic        [NUM_CH-1:0]  r_snap_en_l;
  logic        [NUM_CH-1:0]  r_snap_en_r;
  logic        [2:0]         r_snap_master_l;
  logic        [2:0]         r_snap_master_r;
  logic        [c_IDX_W-1:0] r_idx;
  logic signed [c_ACC_W-1:0] r_acc_l;
  logic signed [c_ACC_W-1:0] r_acc_r;

  logic signed [c_ACC_W-1:0] w_data_x;
  logic signed [c_ACC_W-1:0] w_vol_x;
  logic signed [c_ACC_W-1:0] w_prod;
  logic                      w_last;
  logic signed [OUT_W-1:0]   w_sample_l;
  logic signed [OUT_W-1:0]   w_sample_r;

  // Volume is unsigned, so it is zero-extended before the signed multiply
  assign w_data_x = c_ACC_W'(r_snap_data[r_idx]);
  assign w_vol_x  = c_ACC_W'($signed({1'b0, r_snap_vol[r_idx]}));
  assign w_prod   = w_data_x * w_vol_x;
  assign w_last   = (r_idx == c_IDX_W'(NUM_CH - 1));
  assign busy     = (r_state != IDLE);

  // State register
  always_ff @(posedge clk_100) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state and per-state datapath strobes
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_accum      = 1'b0;
    w_scale      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (codec.sample_req) begin
          w_load       = 1'b1;
          w_state_next = ACCUM;
        end
      end
      ACCUM: begin
        w_accum = 1'b1;
        if (w_last) w_state_next = SCALE;
      end
      SCALE: begin
        w_scale      = 1'b1;
        w_state_next = PRESENT;
      end
      PRESENT: begin
        if (codec.out_ready) begin
          w_done       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Snapshot of all mixing inputs; later input changes do not affect this mix
  always_ff @(posedge clk_100) begin
    if (w_load) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_snap_data[i] <= $signed(ch_data[i*IN_W +: IN_W]);
        r_snap_vol[i]  <= ch_vol[i*VOL_W +: VOL_W];
      end
      r_snap_en_l     <= ch_en_l;
      r_snap_en_r     <= ch_en_r;
      r_snap_master_l <= master_l;
      r_snap_master_r <= master_r;
    end
  end

  // Accumulators, channel index and the presented output sample
  always_ff @(posedge clk_100) begin
    if (!reset_n) begin
      r_idx           <= '0;
      r_acc_l         <= '0;
      r_acc_r         <= '0;
      codec.out_l     <= '0;
      codec.out_r     <= '0;
      codec.out_valid <= 1'b0;
    end else begin
      if (w_load) begin
        r_idx   <= '0;
        r_acc_l <= '0;
        r_acc_r <= '0;
      end
      if (w_accum) begin
        r_acc_l <= r_acc_l + (r_snap_en_l[r_idx] ? w_prod : '0);
        r_acc_r <= r_acc_r + (r_snap_en_r[r_idx] ? w_prod : '0);
        r_idx   <= r_idx + c_IDX_W'(1);
      end
      if (w_scale) begin
        codec.out_l     <= w_sample_l;
        codec.out_r     <= w_sample_r;
        codec.out_valid <= 1'b1;
      end
      if (w_done) codec.out_valid <= 1'b0;
    end
  end

  // Sticky record of requests dropped while a mix was in flight
  always_ff @(posedge clk_100) begin
    if (!reset_n)                             missed_req <= 1'b0;
    else if (codec.sample_req && r_state != IDLE) missed_req <= 1'b1;
    else if (clr_status)                      missed_req <= 1'b0;
  end

`ifdef AUDIO_MIX_CLIP_STATUS_EN
  logic w_clip_l;
  logic w_clip_r;

  audio_mix_scale #(.ACC_W(c_ACC_W), .OUT_W(OUT_W)) u_scale_l (
    .acc(r_acc_l), .master(r_snap_master_l), .sample(w_sample_l), .clipped(w_clip_l)
  );
  audio_mix_scale #(.ACC_W(c_ACC_W), .OUT_W(OUT_W)) u_scale_r (
    .acc(r_acc_r), .master(r_snap_master_r), .sample(w_sample_r), .clipped(w_clip_r)
  );

  // Sticky saturation flags, captured when the sample is scaled
  always_ff @(posedge clk_100) begin
    if (!reset_n) begin
      clip_l <= 1'b0;
      clip_r <= 1'b0;
    end else begin
      if (w_scale && w_clip_l) clip_l <= 1'b1;
      else if (clr_status)     clip_l <= 1'b0;
      if (w_scale && w_clip_r) clip_r <= 1'b1;
      else if (clr_status)     clip_r <= 1'b0;
    end
  end
`else
  audio_mix_scale #(.ACC_W(c_ACC_W), .OUT_W(OUT_W)) u_scale_l (
    .acc(r_acc_l), .master(r_snap_master_l), .sample(w_sample_l)
  );
  audio_mix_scale #(.ACC_W(c_ACC_W), .OUT_W(OUT_W)) u_scale_r (
    .acc(r_acc_r), .master(r_snap_master_r), .sample(w_sample_r)
  );
`endif

endmodule

`default_nettype wire

// File: doc/audio_mixer_n.md
# audio_mixer_n

Parametrised N-channel audio mixer that supersedes the fixed four-PSG-plus-two-direct-sound mixing path. On each codec sample request it snapshots all channel samples and accumulates them one channel per cycle with per-channel volume and left/right panning. It then applies a GBA-style 3-bit master volume per side, saturates, and presents a stereo sample to the codec interface over a valid/ready handshake.

## Interface
Parameters:
- NUM_CH, 6, number of input channels (4 PSG + 2 direct sound); legal range 1..16
- IN_W, 16, signed channel sample width
- VOL_W, 4, unsigned per-channel volume width
- OUT_W, 24, signed output sample width; must be ≤ ACC_W

Ports:
- clk_100  in  1  system clock
- reset_n  in  1  reset, synchronous, active-low
- sample_req  in  1  single-cycle pulse requesting a new stereo sample (codec new_sample)
- ch_data  in  NUM_CH×IN_W  signed per-channel samples
- ch_vol  in  NUM_CH×VOL_W  per-channel volume, 0 = mute
- ch_en_l  in  NUM_CH  per-channel left enable (NR51-style)
- ch_en_r  in  NUM_CH  per-channel right enable
- master_l  in  3  left master volume, gain (master_l+1)/8
- master_r  in  3  right master volume
- out_l  out  OUT_W  signed left sample
- out_r  out  OUT_W  signed right sample
- out_valid  out  1  output sample valid
- out_ready  in  1  consumer accepts sample
- busy  out  1  high in every state except IDLE
- missed_req  out  1  sticky: a sample_req arrived while not IDLE
- clr_status  in  1  clears sticky status flags

## Operation
- ACC_W = IN_W + VOL_W + $clog2(NUM_CH) + 1; all accumulation is signed at ACC_W with no intermediate overflow.
- FSM states and transitions:
  - IDLE: when sample_req is high, register the ch_data, ch_vol, ch_en_l, ch_en_r, master_l and master_r snapshot, clear both accumulators and idx, then go to ACCUM.
  - ACCUM: p = snap_data[idx] × snap_vol[idx] (signed × zero-extended unsigned). acc_l += ch_en_l[idx] ? p : 0, and likewise acc_r. idx++. After idx = NUM_CH−1 is processed, go to SCALE.
  - SCALE: s = (acc × (master+1)) >>> 3 (arithmetic). Saturate s to the signed OUT_W range. Register the result into out_l/out_r, set out_valid, go to PRESENT.
  - PRESENT: hold out_l, out_r and out_valid stable until out_valid && out_ready. On that cycle clear out_valid and go to IDLE.
- sample_req in any state other than IDLE is dropped and sets missed_req. It is never queued.
- Inputs change freely during mixing; only the snapshot is used.
- clr_status clears missed_req. If clr_status and a new missed event occur in the same cycle, missed_req is set (set wins).
- Reset mid-operation aborts the current mix: the FSM returns to IDLE and out_valid drops on the next edge.

## Timing
- Reset values: out_l = 0, out_r = 0, out_valid = 0, busy = 0, missed_req = 0 (and clip_l/clip_r = 0 when built in). FSM is IDLE, idx = 0.
- Latency: with sample_req high in cycle 0, out_valid is high from cycle NUM_CH+2 (NUM_CH ACCUM cycles plus 1 SCALE cycle). Default parameters give cycle 8.
- Minimum request spacing for no drop: NUM_CH+3 cycles with out_ready held high.
- A sample_req in the same cycle as the PRESENT handshake is dropped, because the FSM is not yet IDLE.
- out_ready is ignored when out_valid is low.

## Configuration
- AUDIO_MIX_CLIP_STATUS_EN defined: adds outputs clip_l and clip_r (1 bit each, sticky). Each is set in SCALE when the corresponding side saturated and cleared by clr_status, with set winning over clear.
- Undefined: no clip ports and no clip logic. Saturation itself is always present.

## Structure
- Shared package audio_pkg holds:
  - the mixer_state_t enum (IDLE, ACCUM, SCALE, PRESENT)
  - the saturate-to-width function
  - default constants AUDIO_NUM_CH, AUDIO_IN_W and AUDIO_OUT_W, reused by the channel generators
- One sub-module, audio_mix_scale: combinational master-volume multiply, shift and saturate. It is instantiated once per side.

## Test plan
- Defaults; ch0 = 1000, vol0 = 15, enabled on both sides; others muted; master = 7; pulse sample_req -> out_valid in cycle 8 with out_l = out_r = 15000.
- Same setup with master_l = 3, master_r = 0 -> out_l = 7500, out_r = 1875.
- All 6 channels at +32767, vol 15, both sides, master 7, OUT_W = 16 -> out = 32767. With AUDIO_MIX_CLIP_STATUS_EN, clip_l = clip_r = 1. At −32768 -> out = −32768.
- ch_en_l = 6'b000001, ch_en_r = 6'b000010, ch0 = 100, ch1 = −200, vol 1, master 7 -> out_l = 100, out_r = −200.
- Hold out_ready low for 20 cycles and pulse sample_req at cycle 12 -> outputs stable throughout, missed_req = 1; clr_status -> 0.
- Deassert reset_n during ACCUM -> next edge IDLE, out_valid = 0. The next sample_req then produces a correct fresh result.
